pe_array_ctrl: RTL and testbench
================================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-002 The block SHALL provide these ports, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request, sampled only in IDLE
- abort  in  1  cancel the current job
- cfg_k  in  8  kernel length K, the accumulate cycles per output
- cfg_n  in  8  output count N per job
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion
- pe_mode  out  2  PE mode: 0 = reset_mode, 1 = accumulator_mode
- pe_clear  out  1  one-cycle clear pulse to the PE accumulator
- rd_en  out  1  operand buffer read enable
- in_addr  out  8  input buffer address
- flt_addr  out  8  filter buffer address
- pe_result  in  8  PE output
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  8  captured result
- res_idx  out  8  index of the current output
REQ-003 Operand buffers SHALL be read asynchronously: data for in_addr/flt_addr reaches the PE in the same cycle.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, CLEAR, ACC, CAPT, OUT, DONE.
REQ-005 In IDLE, start=1 with cfg_k!=0 and cfg_n!=0 SHALL latch K and N, set out_idx=0, and go to CLEAR.
REQ-006 In IDLE, start=1 with cfg_k=0 or cfg_n=0 SHALL go to DONE without producing any result.
REQ-007 start SHALL be ignored in every state except IDLE, and cfg_k/cfg_n changes after latching SHALL have no effect on the running job.
REQ-008 CLEAR SHALL last 1 cycle with pe_clear=1, pe_mode=0, rd_en=0, k_cnt=0, then go to ACC.
REQ-009 ACC SHALL last exactly K cycles with:
- pe_mode=1
- rd_en=1
- flt_addr=k_cnt
- in_addr=(out_idx+k_cnt) mod 256
- k_cnt incrementing each cycle from 0 to K-1
REQ-010 After the ACC cycle with k_cnt=K-1, the FSM SHALL go to CAPT.
REQ-011 CAPT SHALL last 1 cycle with pe_mode=0 and rd_en=0, SHALL register pe_result into res_data (the PE's registered mode is still 1 in this cycle), and then go to OUT.
REQ-012 In OUT, res_valid SHALL be 1, and res_data and res_idx=out_idx SHALL stay stable until res_ready=1.
REQ-013 In OUT with res_ready=1, if out_idx=N-1 the FSM SHALL go to DONE; otherwise it SHALL increment out_idx and go to CLEAR.
REQ-014 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-015 busy SHALL be 0 only in IDLE.
REQ-016 pe_mode SHALL never take the values 2 or 3.
REQ-017 Minimum throughput SHALL be K+3 cycles per output when res_ready is held high.
REQ-018 Arithmetic: all counters and addresses SHALL be 8-bit unsigned with modulo-256 wrap; result overflow SHALL be the PE's concern and SHALL not be checked by this block.
REQ-019 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with:
- res_valid dropped
- no done pulse
- pe_mode=0
- rd_en=0
REQ-020 abort SHALL take precedence over start, res_ready, and counter-terminal events.
REQ-021 abort in IDLE SHALL have no effect.
REQ-022 All outputs SHALL be registered or decoded solely from state and counters; no input SHALL combinationally reach any output.

Reset
REQ-023 rst=1 SHALL take priority over all other inputs, including abort.
REQ-024 On rst, state SHALL go to IDLE and k_cnt, out_idx, and res_data SHALL go to 0.
REQ-025 During and after reset: busy=0, done=0, pe_mode=0, pe_clear=0, rd_en=0, in_addr=0, flt_addr=0, res_valid=0, res_idx=0.
REQ-026 rst asserted mid-job SHALL discard the job: no done pulse and no res_valid after reset release until a new start.

Verification
REQ-027 The bench SHALL cover at least these scenarios:
- Basic job: K=3, N=2, res_ready=1, with the PE model fed input[i]=i+1 and filter[i]=1 -> res_data=6 (idx 0) then 9 (idx 1); done exactly 12 cycles after the first CLEAR cycle.
- Backpressure: res_ready=0 for 5 cycles in OUT -> res_valid stays high, res_data and res_idx stable, no address activity; then one handshake.
- Zero config: start with cfg_k=0, N=4 -> done on the 2nd cycle, res_valid never asserted, pe_mode stays 0.
- Abort: abort during ACC at k_cnt=1 -> IDLE next cycle, busy=0, no done; a following start runs normally from out_idx=0.
- Ignored start and wrap: start pulsed while busy -> ignored. Separately, N=200 with K=100 -> in_addr wraps past 255 to 0.
- Reset mid-job: rst in OUT -> all outputs at their REQ-025 values next cycle, no done, no res_valid until a new start.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl
//   Sequencer for one processing element (PE) that runs a 1-D convolution job.
//   For each of N outputs it clears the PE accumulator, streams K operand
//   pairs from the input/filter buffers, captures the PE result, and offers
//   it on a valid/ready result port. Then it moves to the next output.
//
// Result handshake: res_valid is high for the whole OUT state. A transfer
//   happens on a rising edge where res_valid=1 and res_ready=1. While waiting,
//   res_data and res_idx hold steady. res_valid never depends on res_ready.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start, abort         job request (seen only in IDLE) / cancel current job
//   cfg_k, cfg_n         kernel length K, output count N (latched at start)
//   busy, done           not-IDLE indicator / one-cycle completion pulse
//   pe_mode, pe_clear    PE control: 0 = reset_mode, 1 = accumulator_mode
//   rd_en, in_addr,      operand buffer read enable and addresses; the
//   flt_addr             buffers are read asynchronously
//   pe_result            PE accumulator output
//   res_valid/ready,     result handshake, captured result, output index
//   res_data, res_idx
module pe_array_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_k,
  input  logic [7:0] cfg_n,
  output logic       busy,
  output logic       done,
  output logic [1:0] pe_mode,
  output logic       pe_clear,
  output logic       rd_en,
  output logic [7:0] in_addr,
  output logic [7:0] flt_addr,
  input  logic [7:0] pe_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [7:0] res_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] k_lat_q, k_lat_d;      // K latched at job start
  logic [7:0] n_lat_q, n_lat_d;      // N latched at job start
  logic [7:0] k_cnt_q, k_cnt_d;      // accumulate step within one output
  logic [7:0] out_idx_q, out_idx_d;  // current output index
  logic [7:0] res_data_q, res_data_d;

  always_comb begin
    state_d    = state_q;
    k_lat_d    = k_lat_q;
    n_lat_d    = n_lat_q;
    k_cnt_d    = k_cnt_q;
    out_idx_d  = out_idx_q;
    res_data_d = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_k != 8'd0 && cfg_n != 8'd0) begin
            k_lat_d   = cfg_k;
            n_lat_d   = cfg_n;
            out_idx_d = 8'd0;
            state_d   = S_CLEAR;
          end else begin
            // An empty job still signals completion so the host is not left waiting.
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        k_cnt_d = 8'd0;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (k_cnt_q == k_lat_q - 8'd1) begin
          state_d = S_CAPT;
        end else begin
          k_cnt_d = k_cnt_q + 8'd1;
        end
      end
      S_CAPT: begin
        // The PE updated its accumulator on the edge ending the last ACC
        // cycle, so pe_result already holds the full sum here.
        res_data_d = pe_result;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          if (out_idx_q == n_lat_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            out_idx_d = out_idx_q + 8'd1;
            state_d   = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition above, including a completing handshake.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      k_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_lat_q    <= 8'd0;
      n_lat_q    <= 8'd0;
      k_cnt_q    <= 8'd0;
      out_idx_q  <= 8'd0;
      res_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      k_lat_q    <= k_lat_d;
      n_lat_q    <= n_lat_d;
      k_cnt_q    <= k_cnt_d;
      out_idx_q  <= out_idx_d;
      res_data_q <= res_data_d;
    end
  end

  // All outputs decode from registered state and counters only.
  // Addresses are forced to 0 outside ACC so the buffers see no activity while idle or stalled.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pe_mode   = (state_q == S_ACC) ? 2'd1 : 2'd0;
  assign pe_clear  = (state_q == S_CLEAR);
  assign rd_en     = (state_q == S_ACC);
  assign flt_addr  = (state_q == S_ACC) ? k_cnt_q : 8'd0;
  assign in_addr   = (state_q == S_ACC) ? (out_idx_q + k_cnt_q) : 8'd0;
  assign res_valid = (state_q == S_OUT);
  assign res_data  = res_data_q;
  assign res_idx   = out_idx_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl
//   Directed bench for pe_array_ctrl with a behavioural PE and operand buffers.
//   Expected results ({idx, data}) are queued when a job is launched. They are
//   popped and compared when a result handshake happens.
module tb_pe_array_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] cfg_k, cfg_n;
  logic       busy, done, pe_clear, rd_en, res_valid, res_ready;
  logic [1:0] pe_mode;
  logic [7:0] in_addr, flt_addr, pe_result, res_data, res_idx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int valid_cnt = 0;

  logic [15:0] exp_q[$];

  logic [7:0] in_mem  [256];
  logic [7:0] flt_mem [256];
  logic [7:0] acc_q = 8'd0;

  always #5 clk = ~clk;

  pe_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_k(cfg_k), .cfg_n(cfg_n), .busy(busy), .done(done),
    .pe_mode(pe_mode), .pe_clear(pe_clear), .rd_en(rd_en),
    .in_addr(in_addr), .flt_addr(flt_addr), .pe_result(pe_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx)
  );

  // Behavioural PE: registered accumulator fed by asynchronously read buffers.
  assign pe_result = acc_q;
  always @(posedge clk) begin
    if (pe_clear) acc_q <= 8'd0;
    else if (pe_mode == 2'd1 && rd_en)
      acc_q <= acc_q + 8'(in_mem[in_addr] * flt_mem[flt_addr]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_result(input int idx, input int k);
    logic [7:0] s;
    s = 8'd0;
    for (int j = 0; j < k; j++) s = s + 8'(in_mem[8'(idx + j)] * flt_mem[j]);
    return s;
  endfunction

  task automatic push_job(input int k, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), exp_result(i, k)});
  endtask

  // One clock: settle checks on current outputs, then advance to #1 after the edge.
  task automatic step();
    logic [15:0] e;
    if (res_valid && res_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_idx", res_idx, e[15:8]);
        chk("res_data", res_data, e[7:0]);
      end
    end
    if (done) done_cnt++;
    if (res_valid) valid_cnt++;
    chk("pe_mode_legal", pe_mode[1], 0);
    if (rd_en) chk("in_addr_rel", in_addr, 8'(res_idx + flt_addr));
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pe_mode"}, pe_mode, 0);
    chk({tag, "_pe_clear"}, pe_clear, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_in_addr"}, in_addr, 0);
    chk({tag, "_flt_addr"}, flt_addr, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_idx"}, res_idx, 0);
    chk({tag, "_res_data"}, res_data, 0);
  endtask

  initial begin
    int n;
    int d0;
    int v0;
    logic saw_wrap;

    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cfg_k = 8'd0; cfg_n = 8'd0;
    for (int i = 0; i < 256; i++) begin
      in_mem[i]  = 8'(i + 1);
      flt_mem[i] = 8'd1;
    end

    // Reset state
    step(); step();
    chk_quiet("reset");
    rst = 1'b0;
    step();
    chk_quiet("post_reset");

    // Basic job K=3 N=2; config changes and a start pulse mid-job must not matter
    cfg_k = 8'd3; cfg_n = 8'd2; res_ready = 1'b1;
    exp_q.push_back({8'd0, 8'd6});
    exp_q.push_back({8'd1, 8'd9});
    start = 1'b1;
    step();
    start = 1'b0; cfg_k = 8'd7; cfg_n = 8'd9;
    chk("clear_pe_clear", pe_clear, 1);
    chk("clear_pe_mode", pe_mode, 0);
    chk("clear_rd_en", rd_en, 0);
    chk("clear_busy", busy, 1);
    step(); n = 1;
    chk("acc0_pe_mode", pe_mode, 1);
    chk("acc0_rd_en", rd_en, 1);
    chk("acc0_flt_addr", flt_addr, 0);
    chk("acc0_in_addr", in_addr, 0);
    chk("acc0_pe_clear", pe_clear, 0);
    while (!done && n < 50) begin
      start = (n == 4);
      step();
      n++;
    end
    start = 1'b0;
    chk("basic_done_latency", n, 12);
    step();
    chk("basic_idle_busy", busy, 0);
    chk("basic_done_count", done_cnt, 1);
    chk("basic_sb_empty", exp_q.size(), 0);
    step(); step();
    chk("ignored_start_idle", busy, 0);

    // Backpressure: K=2 N=2, random operands
    for (int i = 0; i < 256; i++) begin
      in_mem[i]  = 8'($urandom_range(0, 255));
      flt_mem[i] = 8'($urandom_range(0, 15));
    end
    cfg_k = 8'd2; cfg_n = 8'd2; res_ready = 1'b0;
    push_job(2, 2);
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    chk("bp_reach_out", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", res_valid, 1);
      chk("bp_data_stable", res_data, exp_q[0][7:0]);
      chk("bp_idx_stable", res_idx, exp_q[0][15:8]);
      chk("bp_no_rd", rd_en, 0);
      chk("bp_in_addr", in_addr, 0);
      step();
    end
    res_ready = 1'b1;
    step();
    chk("bp_after_hs_valid", res_valid, 0);
    chk("bp_after_hs_clear", pe_clear, 1);
    run_until_idle("bp_timeout", 40);
    chk("bp_done_count", done_cnt, d0 + 1);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Zero config: K=0 N=4, then K=2 N=0
    d0 = done_cnt; v0 = valid_cnt;
    cfg_k = 8'd0; cfg_n = 8'd4;
    start = 1'b1; step(); start = 1'b0;
    chk("zero_k_done", done, 1);
    chk("zero_k_busy", busy, 1);
    chk("zero_k_pe_mode", pe_mode, 0);
    step();
    chk("zero_k_idle", busy, 0);
    cfg_k = 8'd2; cfg_n = 8'd0;
    start = 1'b1; step(); start = 1'b0;
    chk("zero_n_done", done, 1);
    step();
    chk("zero_done_count", done_cnt, d0 + 2);
    chk("zero_no_valid", valid_cnt, v0);

    // Abort during ACC at k_cnt=1
    d0 = done_cnt;
    cfg_k = 8'd4; cfg_n = 8'd3;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("abort_at_k1", flt_addr, 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_pe_mode", pe_mode, 0);
    chk("abort_valid", res_valid, 0);
    step(); step();
    chk("abort_no_done", done_cnt, d0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_idle_noeffect", busy, 0);
    cfg_k = 8'd2; cfg_n = 8'd2;
    push_job(2, 2);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_idx0", res_idx, 0);
    run_until_idle("restart_timeout", 40);
    chk("restart_done_count", done_cnt, d0 + 1);
    chk("restart_sb_empty", exp_q.size(), 0);

    // Reset while in OUT
    d0 = done_cnt;
    cfg_k = 8'd2; cfg_n = 8'd3; res_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    chk("rst_reach_out", res_valid, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_quiet("midrst");
    v0 = valid_cnt;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_no_valid", valid_cnt, v0);
    chk("midrst_no_done", done_cnt, d0);

    // Wrap: K=100 N=200, random ready; in_addr passes 255 -> 0
    d0 = done_cnt;
    cfg_k = 8'd100; cfg_n = 8'd200;
    push_job(100, 200);
    saw_wrap = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (busy && n < 40000) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if (rd_en && in_addr == 8'd0 && flt_addr == 8'd99 && res_idx == 8'd157) saw_wrap = 1'b1;
      step();
      n++;
    end
    chk("wrap_timeout", busy, 0);
    chk("wrap_seen", saw_wrap, 1);
    chk("wrap_done_count", done_cnt, d0 + 1);
    chk("wrap_sb_empty", exp_q.size(), 0);
    res_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
